vmicro16_uart_rx_apb: RTL and testbench



---
 rtl/vmicro16_uart_rx_apb.sv | 141 ++++++++++++++
 tb/tb_vmicro16_uart_rx_apb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vmicro16_uart_rx_apb.sv
// vmicro16_uart_rx_apb: 8N1 UART receiver with RX FIFO and APB slave registers.
// Optional even parity bit (8E1) when VMICRO16_UART_RX_PARITY_EN is defined.
module vmicro16_uart_rx_apb #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic [1:0]            S_PADDR,
    input  logic                  S_PWRITE,
    input  logic                  S_PSELx,
    input  logic                  S_PENABLE,
    input  logic [DATA_WIDTH-1:0] S_PWDATA,
    output logic [DATA_WIDTH-1:0] S_PRDATA,
    output logic                  S_PREADY,
    output logic                  irq_rx
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int CW   = $clog2(CPB);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`ifdef VMICRO16_UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    logic [1:0]      sync_q;
    logic            rxs, done;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_q, push_d, bad_q, bad_d, fe_set, pe_set;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_q, wr_q;
    logic [CNTW-1:0] count_q;
    logic            fe_q, ov_q, pe_q;
    logic            empty, full, pop, push_ok, ctrl_wr, flush;
    logic [DATA_WIDTH-1:0] status;
    logic            unused_wdata;

    assign rxs  = sync_q[1];
    assign done = cnt_q == '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = done ? cnt_q : cnt_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        bad_d   = bad_q;
        push_d  = 1'b0;
        fe_set  = 1'b0;
        pe_set  = 1'b0;
        case (state_q)
            IDLE: if (!rxs) begin
                state_d = START;
                cnt_d   = CW'(CPB / 2 - 1);
                bad_d   = 1'b0;
            end
            START: if (done) begin
                state_d = rxs ? IDLE : DATA;
                cnt_d   = CW'(CPB - 1);
                bit_d   = '0;
            end
            DATA: if (done) begin
                shift_d = {rxs, shift_q[7:1]};
                cnt_d   = CW'(CPB - 1);
                bit_d   = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? AFTER_DATA : DATA;
            end
            PARITY: if (done) begin
                cnt_d   = CW'(CPB - 1);
                state_d = STOP;
                pe_set  = rxs != ^shift_q;
                bad_d   = rxs != ^shift_q;
            end
            STOP: if (done) begin
                // back to IDLE at mid-stop so a back-to-back start bit is caught
                state_d = IDLE;
                push_d  = rxs & !bad_q;
                fe_set  = !rxs;
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty   = count_q == '0;
    assign full    = count_q == CNTW'(FIFO_DEPTH);
    assign pop     = S_PSELx & S_PENABLE & !S_PWRITE & (S_PADDR == 2'd0) & !empty;
    assign push_ok = push_q & (!full | pop);
    assign ctrl_wr = S_PSELx & S_PENABLE & S_PWRITE & (S_PADDR == 2'd2);
    assign flush   = ctrl_wr & S_PWDATA[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
            bad_q   <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
            pe_q    <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], rxd};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            bad_q   <= bad_d;
            fe_q    <= fe_set | (fe_q & !(ctrl_wr & S_PWDATA[0]));
            ov_q    <= (push_q & full & !pop) | (ov_q & !(ctrl_wr & S_PWDATA[1]));
            pe_q    <= pe_set | (pe_q & !(ctrl_wr & S_PWDATA[3]));
            rd_q    <= flush ? '0 : rd_q + AW'(pop);
            wr_q    <= flush ? '0 : wr_q + AW'(push_ok);
            count_q <= flush ? '0 : count_q + CNTW'(push_ok) - CNTW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_q] <= shift_q;
    end

    assign status = DATA_WIDTH'({4'(count_q), 3'b000, pe_q, ov_q, fe_q, full, empty});
    assign S_PRDATA = !S_PSELx ? '0 :
                      S_PADDR == 2'd0 ? (empty ? '0 : DATA_WIDTH'(mem[rd_q])) :
                      S_PADDR == 2'd1 ? status : '0;
    assign S_PREADY = 1'b1;
    assign irq_rx   = !empty;
    assign unused_wdata = ^S_PWDATA[DATA_WIDTH-1:4];
endmodule

// File: tb/tb_vmicro16_uart_rx_apb.sv
// tb_vmicro16_uart_rx_apb: randomized and directed bench with a queue-based FIFO/flag model.
`timescale 1ns/1ps
module tb_vmicro16_uart_rx_apb;
`ifdef VMICRO16_UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic clk = 1'b0, reset = 1'b1, rxd = 1'b1;
    logic [1:0] paddr = '0;
    logic pwrite = 1'b0, psel = 1'b0, penable = 1'b0;
    logic [15:0] pwdata = '0;
    logic [15:0] prdata;
    logic pready, irq;
    int cyc = 0, errs = 0, checks = 0, off = 0, fs_k = 0;
    bit busy = 1'b1;
    logic [7:0] q[$];
    logic fe_m = 1'b0, ov_m = 1'b0;
    logic [15:0] v;

    vmicro16_uart_rx_apb #(.CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .S_PADDR(paddr), .S_PWRITE(pwrite),
        .S_PSELx(psel), .S_PENABLE(penable), .S_PWDATA(pwdata), .S_PRDATA(prdata),
        .S_PREADY(pready), .irq_rx(irq));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] status_m();
        int n = q.size();
        return {4'b0, 4'(n), 3'b0, 1'b0, ov_m, fe_m, n == 8, n == 0};
    endfunction

    always @(negedge clk) begin
        if (!busy && !reset) begin
            chk("irq_rx", 16'(irq), 16'(q.size() != 0));
            chk("pready", 16'(pready), 16'd1);
            if (!psel) chk("prdata_idle", prdata, 16'h0);
        end
    end

    task automatic apb(input logic [1:0] a, input logic w, input logic [15:0] wd, output logic [15:0] rd);
        @(posedge clk); #1;
        psel = 1'b1; paddr = a; pwrite = w; pwdata = wd; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        #3 rd = prdata;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic rd_data(input string nm, output logic [15:0] d);
        logic [15:0] e;
        apb(2'd0, 1'b0, 16'h0, d);
        e = (q.size() != 0) ? {8'h00, q.pop_front()} : 16'h0;
        chk(nm, d, e);
    endtask

    task automatic rd_status(input string nm, output logic [15:0] d);
        apb(2'd1, 1'b0, 16'h0, d);
        chk(nm, d, status_m());
    endtask

    task automatic wr_ctrl(input logic [15:0] w);
        logic [15:0] d;
        apb(2'd2, 1'b1, w, d);
        if (w[2]) q.delete();
        if (w[0]) fe_m = 1'b0;
        if (w[1]) ov_m = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [NB-1:0] bits;
        busy = 1'b1;
`ifdef VMICRO16_UART_RX_PARITY_EN
        bits = {stop, ^b, b, 1'b0};
`else
        bits = {stop, b, 1'b0};
`endif
        @(posedge clk); #1;
        fs_k = cyc;
        for (int i = 0; i < NB; i++) begin
            rxd = bits[i];
            repeat (10) @(posedge clk);
            #1;
        end
        rxd = 1'b1;
        if (!stop) fe_m = 1'b1;
        else if (q.size() == 8) ov_m = 1'b1;
        else q.push_back(b);
        busy = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", 16'(irq), 16'h0);
        chk("rst_pready", 16'(pready), 16'h1);
        chk("rst_prdata", prdata, 16'h0);
        reset = 1'b0;
        busy = 1'b0;
        rd_status("rst_status", v);
        chk("rst_status_lit", v, 16'h0001);

        // single byte, and where in the frame the interrupt rises
        fs_k = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait (fs_k != 0);
                for (int i = 0; i < 400 && off == 0; i++) begin
                    @(negedge clk);
                    if (irq) off = cyc - fs_k;
                end
            end
        join
        chk("irq_rise_in_stop", 16'(off > (NB - 1) * 10 && off <= NB * 10), 16'h1);
        rd_status("t1_status", v);
        chk("t1_status_lit", v, 16'h0100);
        rd_data("t1_data", v);
        chk("t1_data_lit", v, 16'h00A5);
        rd_status("t1_status2", v);
        chk("t1_status2_lit", v, 16'h0001);
        @(negedge clk);
        chk("t1_irq_low", 16'(irq), 16'h0);

        // false start
        busy = 1'b1;
        @(posedge clk); #1 rxd = 1'b0;
        repeat (3) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (20) @(posedge clk);
        busy = 1'b0;
        rd_status("t2_status", v);
        chk("t2_status_lit", v, 16'h0001);
        send_frame(8'h5A, 1'b1);
        rd_data("t2_data", v);
        chk("t2_data_lit", v, 16'h005A);

        // framing error
        send_frame(8'h3C, 1'b0);
        rd_status("t3_status", v);
        chk("t3_status_lit", v, 16'h0005);
        wr_ctrl(16'h0001);
        rd_status("t3_status2", v);
        chk("t3_status2_lit", v, 16'h0001);

        // overrun
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        rd_status("t4_status", v);
        chk("t4_status_lit", v, 16'h080A);
        for (int i = 1; i <= 8; i++) begin
            rd_data("t4_data", v);
            chk("t4_data_lit", v, 16'(i));
        end
        wr_ctrl(16'h0002);
        rd_status("t4_status2", v);
        chk("t4_status2_lit", v, 16'h0001);

        // full FIFO with a pop landing on the push edge
        for (int i = 0; i < 8; i++) send_frame(8'(8'h40 + i), 1'b1);
        fs_k = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                logic [15:0] d;
                wait (fs_k != 0);
                wait (cyc >= fs_k + off - 3);
                rd_data("t5_coinc_rd", d);
                chk("t5_coinc_rd_lit", d, 16'h0040);
            end
        join
        rd_status("t5_status", v);
        chk("t5_status_lit", v, 16'h0802);
        for (int i = 0; i < 8; i++) rd_data("t5_data", v);
        chk("t5_last_lit", v, 16'h0055);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int r = int'($urandom_range(0, 9));
            if (r <= 3) send_frame(8'($urandom), $urandom_range(0, 7) != 0);
            else if (r <= 5) rd_data("rnd_data", v);
            else if (r == 6) rd_status("rnd_status", v);
            else if (r == 7) wr_ctrl(16'($urandom_range(0, 7)));
            else if (r == 8) begin
                apb($urandom_range(0, 1) != 0 ? 2'd0 : 2'd3, 1'b1, 16'($urandom), v);
                rd_status("rnd_ign_wr", v);
            end else begin
                apb(2'd2 + 2'($urandom_range(0, 1)), 1'b0, 16'h0, v);
                chk("rnd_rd_zero", v, 16'h0);
            end
        end
        rd_status("rnd_final", v);

        // reset during data bit 4 of 0xFF
        busy = 1'b1;
        @(posedge clk); #1 rxd = 1'b0;
        repeat (10) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (45) @(posedge clk);
        #1 reset = 1'b1;
        q.delete();
        fe_m = 1'b0;
        ov_m = 1'b0;
        #1 chk("t6_rst_irq", 16'(irq), 16'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        busy = 1'b0;
        rd_status("t6_status", v);
        chk("t6_status_lit", v, 16'h0001);
        send_frame(8'h12, 1'b1);
        rd_data("t6_data", v);
        chk("t6_data_lit", v, 16'h0012);
        rd_status("t6_status2", v);
        chk("t6_status2_lit", v, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
